gshare_predictor: RTL and testbench
===================================

Name: gshare_predictor

Overview:
- Parametrised next-generation branch direction predictor for the IF unit.
- Selectable bimodal or gshare indexing into a table of saturating counters of configurable width.
- Keeps a speculative global history register (GHR); fetch gets a GHR snapshot per branch, and the ROB returns it at commit for indexed update and history repair.
- A post-reset init FSM sweeps the table one entry per cycle.

Parameters:
- INDEX_LEN, 8, table index width; table depth = 2^INDEX_LEN.
- CNT_BITS, 2, counter width (legal 2..4).
- GHR_LEN, 6, history length (legal 1..INDEX_LEN).
- USE_GSHARE, 1, 1 = index is PC bits XOR GHR; 0 = bimodal, PC bits only (GHR is still maintained).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- query_valid  in  1  fetch consumes this prediction this cycle
- query_pc  in  32  PC of fetched instruction
- query_inst  in  32  fetched instruction word
- predicted_jump  out  1  predicted taken
- predicted_imm  out  32  sign-extended J-imm if JAL, else B-imm
- query_ghr  out  GHR_LEN  GHR snapshot to carry with the instruction to the ROB
- ready  out  1  init sweep complete
- ena_from_rob  in  1  committed conditional branch update
- taken_from_rob  in  1  actual outcome
- mispredict_from_rob  in  1  predicted direction was wrong
- pc_from_rob  in  32  PC of committed branch
- ghr_from_rob  in  GHR_LEN  snapshot returned with that branch

Behaviour:
- Async reset (rst high): state = INIT, sweep_idx = 0, GHR = 0, ready = 0.
- FSM INIT: each cycle write counter[sweep_idx] = 2^(CNT_BITS-1)-1 (weakly not taken), then sweep_idx++.
  - At the last index (2^INDEX_LEN - 1): go to RUN, ready = 1 the next cycle.
  - Sweep takes exactly 2^INDEX_LEN cycles.
- FSM RUN: absorbing until reset. Reset asserted mid-sweep or mid-run restarts INIT at index 0.
- Query index: q_idx = query_pc[INDEX_LEN+1:2] XOR zero-extended GHR (USE_GSHARE=1), else query_pc[INDEX_LEN+1:2].
- Prediction is purely combinational on current state:
  - opcode 1101111 (JAL) -> predicted_jump = 1.
  - opcode 1100011 (BR) -> MSB of counter[q_idx], forced 0 while ready = 0.
  - Any other opcode, including JALR -> 0.
- query_ghr is the current GHR.
- Speculative history: when query_valid, opcode is BR and ready = 1, the next cycle GHR = {GHR[GHR_LEN-2:0], predicted_jump}. JAL and non-branches leave GHR unchanged.
- Update index: u_idx = pc_from_rob[INDEX_LEN+1:2] XOR ghr_from_rob (gshare mode), else the PC bits only.
- Counter update when ena_from_rob and ready = 1:
  - taken -> counter +1, saturating at 2^CNT_BITS - 1.
  - not taken -> counter -1, saturating at 0.
  - Write is visible to queries the next cycle.
- History repair: when ena_from_rob and mispredict_from_rob, the next cycle GHR = {ghr_from_rob[GHR_LEN-2:0], taken_from_rob}.
  - Repair has priority over a same-cycle speculative shift, because fetch is being flushed.
- Same-cycle query and update to the same index: the query sees the old counter value.
- ena_from_rob while ready = 0 is ignored: no counter write, no GHR change.
- Width rule: all index math is INDEX_LEN bits wide; GHR is zero-extended on the MSB side.
- GHR_LEN = 1: the shift degenerates to GHR = new bit.

Test Plan:
- Reset, hold inputs idle -> ready = 0 for 256 cycles, ready = 1 on cycle 257. A BR query at any PC during the sweep gives predicted_jump = 0. A JAL query during the sweep gives predicted_jump = 1, predicted_imm = 0x00000010 for inst 0x0100006F.
- Defaults, USE_GSHARE=0, PC 0x100, BR inst 0xFE000EE3 -> predicted_jump = 0, predicted_imm = 0xFFFFFFFC.
  - After 1 taken update at 0x100 -> predicted_jump = 1.
  - After 3 more taken then 1 not-taken -> still 1 (saturated at 3, now 2).
- Saturation at 0: 5 not-taken updates at PC 0x200, then 1 taken -> counter = 1, prediction 0.
- Gshare, GHR = 0: 2 BR queries with query_valid, first predicted 1, second predicted 0 -> GHR = 6'b000010, and query_ghr shows it. A query at PC 0x100 then indexes 0x40 ^ 0x02 = 0x42.
- Repair priority: GHR = 6'b101010; same cycle as a speculative BR shift, apply mispredict with ghr_from_rob = 6'b000111, taken = 0 -> GHR = 6'b001110.
- Async reset pulse asserted mid-run, between clock edges -> ready drops immediately and GHR = 0 without waiting for a clock edge. Table is reswept: a formerly strong-taken entry predicts 0 after ready returns.

Source files
------------

// File: rtl/gshare_predictor.sv
// Gshare / bimodal branch direction predictor for the fetch unit.
// Holds a table of saturating counters and a speculative global history register that the ROB repairs.
module gshare_predictor #(
    parameter int INDEX_LEN  = 8,
    parameter int CNT_BITS   = 2,
    parameter int GHR_LEN    = 6,
    parameter int USE_GSHARE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 query_valid,
    input  logic [31:0]          query_pc,
    input  logic [31:0]          query_inst,
    output logic                 predicted_jump,
    output logic [31:0]          predicted_imm,
    output logic [GHR_LEN-1:0]   query_ghr,
    output logic                 ready,
    input  logic                 ena_from_rob,
    input  logic                 taken_from_rob,
    input  logic                 mispredict_from_rob,
    input  logic [31:0]          pc_from_rob,
    input  logic [GHR_LEN-1:0]   ghr_from_rob
);

    localparam int DEPTH = 1 << INDEX_LEN;
    localparam logic [CNT_BITS-1:0]  CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
    localparam logic [CNT_BITS-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_BITS-1:0]  CNT_MIN  = '0;
    localparam logic [INDEX_LEN-1:0] LAST_IDX = '1;
    localparam logic [6:0]           OP_JAL   = 7'b1101111;
    localparam logic [6:0]           OP_BR    = 7'b1100011;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   sweep_en;
    logic [INDEX_LEN-1:0]   sweep_idx;
    logic [GHR_LEN-1:0]     ghr;
    logic [GHR_LEN-1:0]     ghr_next;
    logic [CNT_BITS-1:0]    counters [DEPTH];

    logic [6:0]             opcode;
    logic                   is_jal;
    logic                   is_br;
    logic [31:0]            j_imm;
    logic [31:0]            b_imm;
    logic [INDEX_LEN-1:0]   q_idx;
    logic [INDEX_LEN-1:0]   u_idx;
    logic [CNT_BITS-1:0]    q_cnt;
    logic [CNT_BITS-1:0]    u_cnt;
    logic [CNT_BITS-1:0]    u_cnt_next;
    logic                   upd_en;
    logic                   unused_pc_bits;

    // Shift a new outcome into the LSB; written as a loop so GHR_LEN = 1 needs no special case.
    function automatic logic [GHR_LEN-1:0] shift_in(input logic [GHR_LEN-1:0] hist, input logic bit_in);
        logic [GHR_LEN-1:0] res;
        res[0] = bit_in;
        for (int i = 1; i < GHR_LEN; i++) begin
            res[i] = hist[i-1];
        end
        return res;
    endfunction

    // ---------------- init sweep FSM ----------------
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_INIT;
            sweep_idx <= '0;
        end else begin
            state <= state_next;
            if (sweep_en) begin
                sweep_idx <= sweep_idx + 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        sweep_en   = 1'b0;
        case (state)
            ST_INIT: begin
                sweep_en = 1'b1;
                if (sweep_idx == LAST_IDX) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    assign ready = (state == ST_RUN);

    // ---------------- decode and indexing ----------------
    assign opcode = query_inst[6:0];
    assign is_jal = (opcode == OP_JAL);
    assign is_br  = (opcode == OP_BR);

    assign j_imm = {{11{query_inst[31]}}, query_inst[31], query_inst[19:12],
                    query_inst[20], query_inst[30:21], 1'b0};
    assign b_imm = {{19{query_inst[31]}}, query_inst[31], query_inst[7],
                    query_inst[30:25], query_inst[11:8], 1'b0};

    generate
        if (USE_GSHARE != 0) begin : g_gshare
            assign q_idx = query_pc[INDEX_LEN+1:2] ^ INDEX_LEN'(ghr);
            assign u_idx = pc_from_rob[INDEX_LEN+1:2] ^ INDEX_LEN'(ghr_from_rob);
        end else begin : g_bimodal
            assign q_idx = query_pc[INDEX_LEN+1:2];
            assign u_idx = pc_from_rob[INDEX_LEN+1:2];
        end
    endgenerate

    assign unused_pc_bits = ^{query_pc[31:INDEX_LEN+2], query_pc[1:0],
                              pc_from_rob[31:INDEX_LEN+2], pc_from_rob[1:0]};

    // ---------------- prediction ----------------
    assign q_cnt          = counters[q_idx];
    assign predicted_jump = is_jal | (is_br & ready & q_cnt[CNT_BITS-1]);
    assign predicted_imm  = is_jal ? j_imm : b_imm;
    assign query_ghr      = ghr;

    // ---------------- counter update ----------------
    assign upd_en = ena_from_rob & ready;
    assign u_cnt  = counters[u_idx];

    always_comb begin
        u_cnt_next = u_cnt;
        if (taken_from_rob) begin
            if (u_cnt != CNT_MAX) u_cnt_next = u_cnt + 1'b1;
        end else begin
            if (u_cnt != CNT_MIN) u_cnt_next = u_cnt - 1'b1;
        end
    end

    // NOTE: the table has no reset; the INIT sweep gives every entry its starting value instead.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            counters[sweep_idx] <= CNT_INIT;
        end else if (upd_en) begin
            counters[u_idx] <= u_cnt_next;
        end
    end

    // ---------------- global history ----------------
    // A mispredict repair wins over a same-cycle speculative shift since fetch is being flushed.
    always_comb begin
        ghr_next = ghr;
        if (upd_en && mispredict_from_rob) begin
            ghr_next = shift_in(ghr_from_rob, taken_from_rob);
        end else if (query_valid && is_br && ready) begin
            ghr_next = shift_in(ghr, predicted_jump);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr <= '0;
        end else begin
            ghr <= ghr_next;
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: a bimodal and a gshare instance share stimulus;
// expectations go into a scoreboard queue that a negedge monitor drains and compares.
module tb_gshare_predictor;

    localparam logic [31:0] INST_BR   = 32'hFE000EE3;
    localparam logic [31:0] INST_JAL  = 32'h0100006F;
    localparam logic [31:0] INST_JALR = 32'h00008067;

    typedef enum logic [1:0] {K_JUMP, K_IMM, K_GHR, K_READY} kind_e;

    typedef struct {
        string       name;
        bit          use_g;
        kind_e       kind;
        logic [31:0] value;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        query_valid;
    logic [31:0] query_pc;
    logic [31:0] query_inst;
    logic        ena_from_rob;
    logic        taken_from_rob;
    logic        mispredict_from_rob;
    logic [31:0] pc_from_rob;
    logic [5:0]  ghr_from_rob;

    logic        b_jump, g_jump;
    logic [31:0] b_imm, g_imm;
    logic [5:0]  b_ghr, g_ghr;
    logic        b_ready, g_ready;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gshare_predictor #(.INDEX_LEN(8), .CNT_BITS(2), .GHR_LEN(6), .USE_GSHARE(0)) u_bim (
        .clk(clk), .rst(rst),
        .query_valid(query_valid), .query_pc(query_pc), .query_inst(query_inst),
        .predicted_jump(b_jump), .predicted_imm(b_imm), .query_ghr(b_ghr), .ready(b_ready),
        .ena_from_rob(ena_from_rob), .taken_from_rob(taken_from_rob),
        .mispredict_from_rob(mispredict_from_rob), .pc_from_rob(pc_from_rob),
        .ghr_from_rob(ghr_from_rob)
    );

    gshare_predictor #(.INDEX_LEN(8), .CNT_BITS(2), .GHR_LEN(6), .USE_GSHARE(1)) u_gsh (
        .clk(clk), .rst(rst),
        .query_valid(query_valid), .query_pc(query_pc), .query_inst(query_inst),
        .predicted_jump(g_jump), .predicted_imm(g_imm), .query_ghr(g_ghr), .ready(g_ready),
        .ena_from_rob(ena_from_rob), .taken_from_rob(taken_from_rob),
        .mispredict_from_rob(mispredict_from_rob), .pc_from_rob(pc_from_rob),
        .ghr_from_rob(ghr_from_rob)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] sample(input bit use_g, input kind_e kind);
        case (kind)
            K_JUMP:  return {31'b0, use_g ? g_jump : b_jump};
            K_IMM:   return use_g ? g_imm : b_imm;
            K_GHR:   return {26'b0, use_g ? g_ghr : b_ghr};
            default: return {31'b0, use_g ? g_ready : b_ready};
        endcase
    endfunction

    // Monitor: every pending expectation is compared at the falling edge, away from the active edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t it;
            it = sb.pop_front();
            check(it.name, sample(it.use_g, it.kind), it.value);
        end
    end

    // which: 0 = bimodal instance, 1 = gshare instance, 2 = both.
    task automatic expect_out(input string name, input int which, input kind_e kind, input logic [31:0] v);
        if (which != 1) sb.push_back('{name: {name, "/bim"}, use_g: 1'b0, kind: kind, value: v});
        if (which != 0) sb.push_back('{name: {name, "/gsh"}, use_g: 1'b1, kind: kind, value: v});
    endtask

    task automatic idle();
        query_valid         = 1'b0;
        query_pc            = 32'h0;
        query_inst          = 32'h00000013;
        ena_from_rob        = 1'b0;
        taken_from_rob      = 1'b0;
        mispredict_from_rob = 1'b0;
        pc_from_rob         = 32'h0;
        ghr_from_rob        = 6'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic query(input logic valid, input logic [31:0] pc, input logic [31:0] inst);
        query_valid = valid;
        query_pc    = pc;
        query_inst  = inst;
    endtask

    task automatic update(input logic taken, input logic mis, input logic [31:0] pc, input logic [5:0] g);
        ena_from_rob        = 1'b1;
        taken_from_rob      = taken;
        mispredict_from_rob = mis;
        pc_from_rob         = pc;
        ghr_from_rob        = g;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Init sweep: 256 cycles not ready; BR forced 0, JAL still taken, ROB updates ignored.
        for (int k = 0; k < 256; k++) begin
            if (k == 0)   expect_out("ready_sweep_start", 2, K_READY, 32'd0);
            if (k == 255) expect_out("ready_sweep_end", 2, K_READY, 32'd0);
            if (k == 10) begin
                query(1'b1, 32'h300, INST_BR);
                expect_out("br_during_sweep", 2, K_JUMP, 32'd0);
            end
            if (k == 20) begin
                query(1'b1, 32'h300, INST_JAL);
                expect_out("jal_during_sweep", 2, K_JUMP, 32'd1);
                expect_out("jal_imm", 2, K_IMM, 32'h00000010);
            end
            if (k == 200) update(1'b1, 1'b1, 32'h100, 6'h3F);
            tick();
        end
        expect_out("ready_after_sweep", 2, K_READY, 32'd1);
        expect_out("ghr_after_sweep", 2, K_GHR, 32'd0);

        // Counter at index 0x40: 1 -> taken x4 (saturates at 3) -> not-taken -> 2 -> taken -> 3.
        query(1'b0, 32'h100, INST_BR);
        expect_out("br_init_pred", 2, K_JUMP, 32'd0);
        expect_out("br_imm", 2, K_IMM, 32'hFFFFFFFC);
        tick();
        query(1'b0, 32'h100, INST_BR);
        update(1'b1, 1'b0, 32'h100, 6'h0);
        expect_out("same_cycle_old_value", 2, K_JUMP, 32'd0);
        tick();
        query(1'b0, 32'h100, INST_BR);
        update(1'b1, 1'b0, 32'h100, 6'h0);
        expect_out("after_one_taken", 2, K_JUMP, 32'd1);
        tick();
        update(1'b1, 1'b0, 32'h100, 6'h0);
        tick();
        query(1'b0, 32'h100, INST_BR);
        update(1'b1, 1'b0, 32'h100, 6'h0);
        expect_out("saturated_high", 2, K_JUMP, 32'd1);
        tick();
        update(1'b0, 1'b0, 32'h100, 6'h0);
        tick();
        query(1'b0, 32'h100, INST_BR);
        expect_out("sat3_then_nt", 2, K_JUMP, 32'd1);
        update(1'b1, 1'b0, 32'h100, 6'h0);
        tick();

        // Saturation at 0 on index 0x80.
        for (int n = 0; n < 5; n++) begin
            update(1'b0, 1'b0, 32'h200, 6'h0);
            if (n == 2) begin
                query(1'b0, 32'h200, INST_BR);
                expect_out("saturated_low", 2, K_JUMP, 32'd0);
            end
            tick();
        end
        update(1'b1, 1'b0, 32'h200, 6'h0);
        tick();
        query(1'b0, 32'h200, INST_BR);
        expect_out("sat0_then_taken", 2, K_JUMP, 32'd0);
        update(1'b1, 1'b0, 32'h200, 6'h0);
        tick();
        query(1'b0, 32'h200, INST_BR);
        expect_out("sat0_two_taken", 2, K_JUMP, 32'd1);
        tick();

        // Speculative history: predicted 1 then 0 -> GHR = 000010.
        query(1'b1, 32'h100, INST_BR);
        expect_out("spec_q1_pred", 2, K_JUMP, 32'd1);
        expect_out("spec_q1_ghr", 2, K_GHR, 32'h00);
        tick();
        query(1'b1, 32'h400, INST_BR);
        expect_out("spec_q2_pred", 2, K_JUMP, 32'd0);
        expect_out("spec_q2_ghr", 2, K_GHR, 32'h01);
        tick();
        query(1'b0, 32'h100, INST_BR);
        expect_out("spec_ghr", 2, K_GHR, 32'h02);
        expect_out("gshare_idx_42", 1, K_JUMP, 32'd0);
        expect_out("bimodal_idx_40", 0, K_JUMP, 32'd1);
        tick();

        // Repair: first force GHR = 101010, then repair in the same cycle as a speculative shift.
        update(1'b0, 1'b1, 32'h0, 6'b010101);
        tick();
        query(1'b1, 32'h100, INST_BR);
        update(1'b0, 1'b1, 32'h0, 6'b000111);
        expect_out("repair_setup_ghr", 2, K_GHR, 32'h2A);
        tick();
        query(1'b1, 32'h100, INST_JAL);
        expect_out("repair_priority_ghr", 2, K_GHR, 32'h0E);
        expect_out("jal_run", 2, K_JUMP, 32'd1);
        tick();
        query(1'b1, 32'h100, INST_JALR);
        expect_out("jalr_not_taken", 2, K_JUMP, 32'd0);
        expect_out("jal_no_shift", 2, K_GHR, 32'h0E);
        tick();
        query(1'b0, 32'h100, INST_BR);
        expect_out("jalr_no_shift", 2, K_GHR, 32'h0E);
        expect_out("gshare_idx_4e", 1, K_JUMP, 32'd0);
        expect_out("bimodal_idx_40_again", 0, K_JUMP, 32'd1);
        tick();

        // Async reset pulse between edges: ready and GHR drop before any clock edge.
        #2;
        rst = 1'b1;
        expect_out("async_ready", 2, K_READY, 32'd0);
        expect_out("async_ghr", 2, K_GHR, 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        for (int k = 0; k < 256; k++) begin
            if (k == 255) expect_out("resweep_not_ready", 2, K_READY, 32'd0);
            tick();
        end
        query(1'b0, 32'h100, INST_BR);
        expect_out("resweep_ready", 2, K_READY, 32'd1);
        expect_out("resweep_pred", 2, K_JUMP, 32'd0);
        tick();

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
